// File: rtl/packet_framer.sv
// packet_framer: frames a raw upstream word stream into packets for packet_fifo.
// One word is held back in H until it is known whether it ends the packet.
// A packet closes on last_i, on its MAXLEN-th word, or after TIMEOUT idle
// cycles. Any error_i seen in the packet raises drop_o on its final word.
module packet_framer #(
  parameter int  WIDTH   = 8,
  parameter int  MAXLEN  = 64,
  parameter int  TIMEOUT = 16,
  localparam int LBITS   = $clog2(MAXLEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             last_i,
  input  logic             error_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] data_o,
  output logic [LBITS-1:0] count_o
);

  // Idle counter only needs to reach TIMEOUT-1; keep one bit when timeout is disabled.
  localparam int ICW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [LBITS-1:0] LEN_ONE  = LBITS'(1);
  localparam logic [LBITS-1:0] LEN_LAST = LBITS'(MAXLEN - 1);
  localparam logic [ICW-1:0]   IC_ONE   = ICW'(1);
  localparam logic [ICW-1:0]   IC_LAST  = ICW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // Hold-register occupancy viewed as a state machine.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_HOLD  = 2'd1,  // word held, packet end not yet known
    ST_FINAL = 2'd2   // word held and known to close the packet
  } state_e;

  // Hold register H, output register O, sticky error, length and idle counters.
  logic             r_hv, r_hf, r_ef;
  logic [WIDTH-1:0] r_hd;
  logic             r_ov, r_ol, r_odrop;
  logic [WIDTH-1:0] r_od;
  logic [LBITS-1:0] r_len;
  logic [ICW-1:0]   r_ic;

  logic             w_hv_nxt, w_hf_nxt, w_ef_nxt;
  logic [WIDTH-1:0] w_hd_nxt;
  logic             w_ov_nxt, w_ol_nxt, w_odrop_nxt;
  logic [WIDTH-1:0] w_od_nxt;
  logic [LBITS-1:0] w_len_nxt;
  logic [ICW-1:0]   w_ic_nxt;

  state_e w_state;
  logic   w_ofree;
  logic   w_accept;
  logic   w_flush;
  logic   w_ov_drain;

  // Decode (hv, hf) into the named state used by the next-state logic.
  always_comb begin
    if (!r_hv) begin
      w_state = ST_EMPTY;
    end else if (!r_hf) begin
      w_state = ST_HOLD;
    end else begin
      w_state = ST_FINAL;
    end
  end

  // O can take a word when empty or draining this cycle; a final held word blocks upstream.
  assign w_ofree    = !r_ov || ready_i;
  assign ready_o    = w_ofree && (w_state != ST_FINAL);
  assign w_accept   = valid_i && ready_o;
  assign w_flush    = (w_state == ST_FINAL) && w_ofree;
  assign w_ov_drain = r_ov && !ready_i;

  // Next-state for H, O, error flag, length and idle counter.
  always_comb begin
    w_hv_nxt    = r_hv;
    w_hf_nxt    = r_hf;
    w_hd_nxt    = r_hd;
    w_ef_nxt    = r_ef;
    w_ov_nxt    = w_ov_drain;
    w_ol_nxt    = r_ol;
    w_od_nxt    = r_od;
    w_odrop_nxt = r_odrop;
    w_len_nxt   = r_len;
    w_ic_nxt    = r_ic;
    case (w_state)
      ST_EMPTY, ST_HOLD: begin
        if (w_accept) begin
          // A previously held word is now known not to be final: push it to O.
          if (w_state == ST_HOLD) begin
            w_ov_nxt    = 1'b1;
            w_ol_nxt    = 1'b0;
            w_od_nxt    = r_hd;
            w_odrop_nxt = 1'b0;
          end else begin
            w_ov_nxt    = w_ov_drain;
          end
          w_hv_nxt  = 1'b1;
          w_hd_nxt  = data_i;
          w_hf_nxt  = last_i || (r_len == LEN_LAST);
          w_ef_nxt  = r_ef | error_i;
          w_len_nxt = r_len + LEN_ONE;
          w_ic_nxt  = {ICW{1'b0}};
        end else if ((w_state == ST_HOLD) && TO_EN) begin
          // Idle while holding: close the packet after TIMEOUT idle edges.
          if (r_ic == IC_LAST) begin
            w_hf_nxt = 1'b1;
            w_ic_nxt = {ICW{1'b0}};
          end else begin
            w_ic_nxt = r_ic + IC_ONE;
          end
        end else begin
          w_ic_nxt = {ICW{1'b0}};
        end
      end
      ST_FINAL: begin
        if (w_flush) begin
          w_ov_nxt    = 1'b1;
          w_ol_nxt    = 1'b1;
          w_od_nxt    = r_hd;
          w_odrop_nxt = r_ef;
          w_hv_nxt    = 1'b0;
          w_hf_nxt    = 1'b0;
          w_ef_nxt    = 1'b0;
          w_len_nxt   = {LBITS{1'b0}};
          w_ic_nxt    = {ICW{1'b0}};
        end else begin
          w_ic_nxt    = {ICW{1'b0}};
        end
      end
      default: begin
        w_hv_nxt  = 1'b0;
        w_hf_nxt  = 1'b0;
        w_ef_nxt  = 1'b0;
        w_len_nxt = {LBITS{1'b0}};
        w_ic_nxt  = {ICW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hv    <= 1'b0;
      r_hf    <= 1'b0;
      r_hd    <= {WIDTH{1'b0}};
      r_ef    <= 1'b0;
      r_ov    <= 1'b0;
      r_ol    <= 1'b0;
      r_od    <= {WIDTH{1'b0}};
      r_odrop <= 1'b0;
      r_len   <= {LBITS{1'b0}};
      r_ic    <= {ICW{1'b0}};
    end else begin
      r_hv    <= w_hv_nxt;
      r_hf    <= w_hf_nxt;
      r_hd    <= w_hd_nxt;
      r_ef    <= w_ef_nxt;
      r_ov    <= w_ov_nxt;
      r_ol    <= w_ol_nxt;
      r_od    <= w_od_nxt;
      r_odrop <= w_odrop_nxt;
      r_len   <= w_len_nxt;
      r_ic    <= w_ic_nxt;
    end
  end

  assign valid_o = r_ov;
  assign last_o  = r_ol;
  assign drop_o  = r_odrop;
  assign data_o  = r_od;
  assign count_o = r_len;

endmodule

// File: tb/tb_packet_framer.sv
// Self-checking bench for packet_framer (MAXLEN=4, TIMEOUT=16).
// A stream-level reference model frames the accepted words from the
// last/maxlen/idle-gap rules and is compared against the emitted stream.
module tb_packet_framer;
  localparam int WIDTH   = 8;
  localparam int MAXLEN  = 4;
  localparam int TIMEOUT = 16;
  localparam int LBITS   = $clog2(MAXLEN + 1);

  logic             clock   = 1'b0;
  logic             reset   = 1'b1;
  logic             valid_i = 1'b0;
  logic             last_i  = 1'b0;
  logic             error_i = 1'b0;
  logic             ready_i = 1'b1;
  logic [WIDTH-1:0] data_i  = '0;
  logic             ready_o, valid_o, last_o, drop_o;
  logic [WIDTH-1:0] data_o;
  logic [LBITS-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { logic [WIDTH-1:0] d; logic l; logic e; int c; } acc_t;
  typedef struct { logic [WIDTH-1:0] d; logic l; logic dr; } out_t;

  acc_t acc_q[$];
  out_t out_q[$];
  out_t exp_q[$];
  acc_t mon_a;
  out_t mon_o;

  packet_framer #(.WIDTH(WIDTH), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i), .error_i(error_i), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .drop_o(drop_o), .data_o(data_o),
    .count_o(count_o)
  );

  always #5 clock = ~clock;

  // cycle counter used to time-stamp accepted words
  always @(posedge clock) cyc <= cyc + 1;

  // record upstream and downstream handshakes that will occur on the next edge
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_i && ready_o) begin
        mon_a.d = data_i; mon_a.l = last_i; mon_a.e = error_i; mon_a.c = cyc;
        acc_q.push_back(mon_a);
      end
      if (valid_o && ready_i) begin
        mon_o.d = data_o; mon_o.l = last_o; mon_o.dr = drop_o;
        out_q.push_back(mon_o);
      end
    end
  end

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: a word is final on last_i, on the MAXLEN-th word of a packet,
  // or when the next accept comes TIMEOUT or more idle cycles later.
  function automatic void build_expected();
    int   pos = 0;
    logic err = 1'b0;
    int   gap;
    logic fin;
    out_t o;
    exp_q.delete();
    for (int i = 0; i < acc_q.size(); i++) begin
      pos++;
      err = err | acc_q[i].e;
      gap = (i + 1 < acc_q.size()) ? (acc_q[i+1].c - acc_q[i].c - 1) : TIMEOUT;
      fin = acc_q[i].l || (pos == MAXLEN) || (gap >= TIMEOUT);
      o.d = acc_q[i].d; o.l = fin; o.dr = fin & err;
      exp_q.push_back(o);
      if (fin) begin pos = 0; err = 1'b0; end
    end
  endfunction

  task automatic clear_q();
    acc_q.delete(); out_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic l, input logic e);
    int waited = 0;
    valid_i = 1'b1; data_i = d; last_i = l; error_i = e;
    @(negedge clock);
    while (!ready_o && waited < 100) begin waited++; @(negedge clock); end
    n_checks++;
    if (!ready_o) begin
      n_fail++;
      $display("FAIL send_word_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, waited);
    end
    @(posedge clock); #1;
    valid_i = 1'b0; last_i = 1'b0; error_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    clear_q();
    @(negedge clock);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", last_o); end
    n_checks++; if (drop_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0b want 0", drop_o); end
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h want 0", data_o); end
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", ready_o); end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] d;
    clear_q();
    d = WIDTH'($urandom);
    send_word(d, 1'b1, 1'b0);
    @(negedge clock);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL single_hold_valid: got %0b want 0", valid_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL single_hold_ready: got %0b want 0", ready_o); end
    n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL single_hold_count: got %0d want 1", count_o); end
    @(negedge clock);
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", valid_o); end
    n_checks++; if (last_o !== 1'b1) begin n_fail++; $display("FAIL single_last: got %0b want 1", last_o); end
    n_checks++; if (drop_o !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %0b want 0", drop_o); end
    n_checks++; if (data_o !== d) begin n_fail++; $display("FAIL single_data: got %0h want %0h", data_o, d); end
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count_o); end
    idle(3);
  endtask

  task automatic test_timeout();
    logic [WIDTH-1:0] w[3];
    int first_k = -1;
    logic [WIDTH-1:0] first_d = '0;
    clear_q();
    for (int i = 0; i < 3; i++) w[i] = WIDTH'($urandom);
    for (int i = 0; i < 3; i++) send_word(w[i], 1'b0, 1'b0);
    for (int k = 0; k <= 25; k++) begin
      @(negedge clock);
      if (first_k < 0 && valid_o && last_o) begin first_k = k; first_d = data_o; end
    end
    n_checks++; if (first_k != 17) begin n_fail++; $display("FAIL timeout_latency: got %0d want 17", first_k); end
    n_checks++; if (first_d !== w[2]) begin n_fail++; $display("FAIL timeout_data: got %0h want %0h", first_d, w[2]); end
    @(posedge clock); #1;
    idle(3);
    build_expected();
    n_checks++;
    if (out_q.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i].d !== exp_q[i].d || out_q[i].l !== exp_q[i].l || out_q[i].dr !== exp_q[i].dr) begin
        n_fail++;
        $display("FAIL timeout_word%0d: got %0h/%0b/%0b want %0h/%0b/%0b", i, out_q[i].d, out_q[i].l, out_q[i].dr, exp_q[i].d, exp_q[i].l, exp_q[i].dr);
      end
    end
  endtask

  task automatic test_maxlen();
    logic [WIDTH-1:0] w[10];
    logic want_l;
    clear_q();
    for (int i = 0; i < 10; i++) w[i] = WIDTH'($urandom);
    for (int i = 0; i < 10; i++) send_word(w[i], 1'b0, 1'b0);
    idle(TIMEOUT + 5);
    n_checks++;
    if (out_q.size() != 10) begin n_fail++; $display("FAIL maxlen_len: got %0d want 10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      want_l = (i == 3) || (i == 7) || (i == 9);
      n_checks++;
      if (out_q[i].d !== w[i] || out_q[i].l !== want_l || out_q[i].dr !== 1'b0) begin
        n_fail++;
        $display("FAIL maxlen_word%0d: got %0h/%0b/%0b want %0h/%0b/0", i, out_q[i].d, out_q[i].l, out_q[i].dr, w[i], want_l);
      end
    end
  endtask

  task automatic test_error();
    clear_q();
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    send_word(8'h33, 1'b1, 1'b0);
    send_word(8'h44, 1'b1, 1'b0);
    idle(5);
    n_checks++;
    if (out_q.size() != 4) begin
      n_fail++; $display("FAIL error_len: got %0d want 4", out_q.size());
    end else begin
      n_checks++;
      if (out_q[1].l !== 1'b0 || out_q[1].d !== 8'h22) begin n_fail++; $display("FAIL error_w2: got %0h/%0b want 22/0", out_q[1].d, out_q[1].l); end
      n_checks++;
      if (out_q[2].l !== 1'b1 || out_q[2].dr !== 1'b1) begin n_fail++; $display("FAIL error_w3: got last=%0b drop=%0b want 1/1", out_q[2].l, out_q[2].dr); end
      n_checks++;
      if (out_q[3].l !== 1'b1 || out_q[3].dr !== 1'b0 || out_q[3].d !== 8'h44) begin n_fail++; $display("FAIL error_next: got %0h/%0b/%0b want 44/1/0", out_q[3].d, out_q[3].l, out_q[3].dr); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] wd[20];
    logic wl[20];
    logic we[20];
    int idx = 0;
    logic stall_prev = 1'b0;
    logic [WIDTH-1:0] held_d = '0;
    logic held_l = 1'b0;
    logic held_dr = 1'b0;
    clear_q();
    for (int i = 0; i < 20; i++) begin
      wd[i] = WIDTH'($urandom);
      wl[i] = ($urandom_range(4) == 0);
      we[i] = ($urandom_range(5) == 0);
    end
    for (int c = 0; c < 400 && idx < 20; c++) begin
      ready_i = ~ready_i;
      if ($urandom_range(3) != 0) begin
        valid_i = 1'b1; data_i = wd[idx]; last_i = wl[idx]; error_i = we[idx];
      end else begin
        valid_i = 1'b0; last_i = 1'b0; error_i = 1'b0;
      end
      @(negedge clock);
      if (stall_prev) begin
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== held_d || last_o !== held_l || drop_o !== held_dr) begin
          n_fail++;
          $display("FAIL bp_stable: got %0b/%0h/%0b/%0b want 1/%0h/%0b/%0b", valid_o, data_o, last_o, drop_o, held_d, held_l, held_dr);
        end
      end
      if (valid_o && !ready_i) begin
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b want 0 while O full and stalled", ready_o); end
      end
      stall_prev = valid_o && !ready_i;
      held_d = data_o; held_l = last_o; held_dr = drop_o;
      if (valid_i && ready_o) idx++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (idx != 20) begin n_fail++; $display("FAIL bp_progress: got %0d words accepted want 20", idx); end
    valid_i = 1'b0; last_i = 1'b0; error_i = 1'b0; ready_i = 1'b1;
    idle(TIMEOUT + 5);
    build_expected();
    n_checks++;
    if (out_q.size() != exp_q.size() || exp_q.size() != 20) begin
      n_fail++; $display("FAIL bp_len: got %0d want %0d (20 sent)", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i].d !== exp_q[i].d || out_q[i].l !== exp_q[i].l || out_q[i].dr !== exp_q[i].dr) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %0h/%0b/%0b want %0h/%0b/%0b", i, out_q[i].d, out_q[i].l, out_q[i].dr, exp_q[i].d, exp_q[i].l, exp_q[i].dr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d;
    clear_q();
    send_word(WIDTH'($urandom), 1'b0, 1'b0);
    send_word(WIDTH'($urandom), 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_q();
    @(negedge clock);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b want 0", valid_o); end
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count_o); end
    @(posedge clock); #1;
    d = WIDTH'($urandom);
    send_word(d, 1'b1, 1'b0);
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (valid_o !== 1'b1 || last_o !== 1'b1 || drop_o !== 1'b0 || data_o !== d) begin
      n_fail++;
      $display("FAIL rstmid_packet: got %0b/%0b/%0b/%0h want 1/1/0/%0h", valid_o, last_o, drop_o, data_o, d);
    end
    @(posedge clock); #1;
    idle(3);
    n_checks++;
    if (out_q.size() != 1) begin n_fail++; $display("FAIL rstmid_len: got %0d want 1", out_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_maxlen();
    test_error();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
